// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: FSM state codes,
// latency counter width, legal byte-mask patterns and mask helpers.
// Optional protocol checking in the responder is enabled by DMEM_PROTO_CHECK_EN.
package dmem_pkg;

  localparam int LAT_W = 4;

  // FSM state codes
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  // Byte-mask patterns an initiator may legally issue (byte, half, word)
  localparam logic [3:0] MASK_B0 = 4'b0001;
  localparam logic [3:0] MASK_B1 = 4'b0010;
  localparam logic [3:0] MASK_B2 = 4'b0100;
  localparam logic [3:0] MASK_B3 = 4'b1000;
  localparam logic [3:0] MASK_H0 = 4'b0011;
  localparam logic [3:0] MASK_H1 = 4'b1100;
  localparam logic [3:0] MASK_W  = 4'b1111;

  // Expand a 4-bit byte mask into a 32-bit lane mask
  function automatic logic [31:0] expand_mask(input logic [3:0] mask);
    logic [31:0] lanes;
    lanes = 32'h0000_0000;
    for (int i = 0; i < 4; i++) begin
      lanes[8*i +: 8] = {8{mask[i]}};
    end
    return lanes;
  endfunction

  // True when the mask is one of the naturally aligned byte/half/word shapes
  function automatic logic mask_is_legal(input logic [3:0] mask);
    logic ok;
    case (mask)
      MASK_B0, MASK_B1, MASK_B2, MASK_B3,
      MASK_H0, MASK_H1, MASK_W: ok = 1'b1;
      default:                  ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Word-addressed storage for the data-memory responder: byte-masked
// synchronous write and a registered synchronous read port. Not reset.
module dmem_array #(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic          re,
  input  logic [AW-1:0] idx,
  input  logic [31:0]   wdata,
  input  logic [31:0]   wlanes,
  output logic [31:0]   rdata
);

  logic [31:0] mem_r [DEPTH];
  logic [31:0] rdata_r;

  // Byte-masked write: only lanes selected by wlanes are replaced
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[idx] <= (mem_r[idx] & ~wlanes) | (wdata & wlanes);
    end
  end

  // Read port samples the addressed word on the read-enable edge and holds it
  always_ff @(posedge clk) begin
    if (re) begin
      rdata_r <= mem_r[idx];
    end
  end

  assign rdata = rdata_r;

endmodule

// File: rtl/dmem_responder.sv
// Responder end of the hart data-memory port. Accepts one load/store at a
// time over valid/ready, commits writes / samples reads on the accept edge,
// and presents the response LATENCY cycles later until it is consumed.
// Optional protocol checking: define DMEM_PROTO_CHECK_EN.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_req_addr,
  input  logic        i_req_ren,
  input  logic        i_req_wen,
  input  logic [31:0] i_req_wdata,
  input  logic [3:0]  i_req_mask,
  output logic        o_req_ready,
  output logic        o_res_valid,
  output logic [31:0] o_res_rdata,
  input  logic        i_res_ready,
  output logic        o_res_err
);

  localparam int              AW       = $clog2(DEPTH);
  localparam logic [LAT_W-1:0] CNT_LOAD = LAT_W'(LATENCY - 1);

  logic [1:0]       state_r;
  logic [1:0]       state_nxt_s;
  logic [LAT_W-1:0] cnt_r;
  logic             req_valid_s;
  logic             accept_s;
  logic             hs_s;
  logic             chk_err_s;
  logic             we_s;
  logic             re_s;
  logic             rd_op_r;
  logic             err_op_r;
  logic [3:0]       mask_r;
  logic             req_ready_r;
  logic             res_valid_r;
  logic [31:0]      res_rdata_r;
  logic             res_err_r;
  logic [31:0]      arr_rdata_s;
  logic             unused_addr_s;

  assign req_valid_s = i_req_ren | i_req_wen;
  assign accept_s    = req_valid_s & req_ready_r;
  assign hs_s        = res_valid_r & i_res_ready;

`ifdef DMEM_PROTO_CHECK_EN
  assign chk_err_s     = (i_req_ren & i_req_wen) | (i_req_addr[1:0] != 2'b00) |
                         ~mask_is_legal(i_req_mask);
  assign unused_addr_s = ^i_req_addr[31:AW+2];
`else
  assign chk_err_s     = 1'b0;
  assign unused_addr_s = ^{i_req_addr[31:AW+2], i_req_addr[1:0]};
`endif

  // Erroneous writes never reach the array; a combined ren&wen is a write
  assign we_s = accept_s & i_req_wen & ~chk_err_s;
  assign re_s = accept_s & i_req_ren & ~i_req_wen;

  dmem_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_array (
    .clk    (i_clk),
    .we     (we_s),
    .re     (re_s),
    .idx    (i_req_addr[AW+1:2]),
    .wdata  (i_req_wdata),
    .wlanes (expand_mask(i_req_mask)),
    .rdata  (arr_rdata_s)
  );

  // Next-state decode: IDLE -> (WAIT) -> RESP -> IDLE
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          if (CNT_LOAD == LAT_W'(0)) begin
            state_nxt_s = ST_RESP;
          end else begin
            state_nxt_s = ST_WAIT;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (cnt_r == LAT_W'(1)) begin
          state_nxt_s = ST_RESP;
        end else begin
          state_nxt_s = ST_WAIT;
        end
      end
      ST_RESP: begin
        if (hs_s) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_RESP;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // FSM, latency counter and registered response outputs
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_r     <= ST_IDLE;
      cnt_r       <= LAT_W'(0);
      req_ready_r <= 1'b1;
      res_valid_r <= 1'b0;
      res_rdata_r <= 32'h0000_0000;
      res_err_r   <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      req_ready_r <= (state_nxt_s == ST_IDLE);
      if (accept_s) begin
        cnt_r <= CNT_LOAD;
      end else if ((state_r == ST_WAIT) && (cnt_r != LAT_W'(0))) begin
        cnt_r <= cnt_r - LAT_W'(1);
      end
      // Valid rises one cycle into RESP, once the sampled read word is in hand
      res_valid_r <= (state_r == ST_RESP) && (state_nxt_s == ST_RESP);
      if ((state_r == ST_RESP) && !res_valid_r) begin
        res_rdata_r <= rd_op_r ? (arr_rdata_s & expand_mask(mask_r)) : 32'h0000_0000;
        res_err_r   <= err_op_r;
      end else if (hs_s) begin
        res_rdata_r <= 32'h0000_0000;
        res_err_r   <= 1'b0;
      end
    end
  end

  // Latch the operation type, error status and mask of the accepted request
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rd_op_r  <= 1'b0;
      err_op_r <= 1'b0;
      mask_r   <= 4'b0000;
    end else if (accept_s) begin
      rd_op_r  <= i_req_ren & ~i_req_wen & ~chk_err_s;
      err_op_r <= chk_err_s;
      mask_r   <= i_req_mask;
    end
  end

  assign o_req_ready = req_ready_r;
  assign o_res_valid = res_valid_r;
  assign o_res_rdata = res_rdata_r;
  assign o_res_err   = res_err_r;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder. Two instances share all request
// inputs: dut0 with LATENCY=2 and dut1 with LATENCY=1.
module tb_dmem_responder;

`ifdef DMEM_PROTO_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] req_addr = 32'h0;
  logic        req_ren = 1'b0;
  logic        req_wen = 1'b0;
  logic [31:0] req_wdata = 32'h0;
  logic [3:0]  req_mask = 4'h0;
  logic        res_ready = 1'b1;
  logic        rdy0, vld0, err0, rdy1, vld1, err1;
  logic [31:0] rd0, rd1;

  int checks = 0;
  int passes = 0;

  logic [31:0] mdl [1024];

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH(1024), .LATENCY(2)) dut0 (
    .i_clk(clk), .i_rst(rst), .i_req_addr(req_addr), .i_req_ren(req_ren),
    .i_req_wen(req_wen), .i_req_wdata(req_wdata), .i_req_mask(req_mask),
    .o_req_ready(rdy0), .o_res_valid(vld0), .o_res_rdata(rd0),
    .i_res_ready(res_ready), .o_res_err(err0));

  dmem_responder #(.DEPTH(1024), .LATENCY(1)) dut1 (
    .i_clk(clk), .i_rst(rst), .i_req_addr(req_addr), .i_req_ren(req_ren),
    .i_req_wen(req_wen), .i_req_wdata(req_wdata), .i_req_mask(req_mask),
    .o_req_ready(rdy1), .o_res_valid(vld1), .o_res_rdata(rd1),
    .i_res_ready(res_ready), .o_res_err(err1));

  // Reference memory: word index is the byte address divided by four, modulo depth
  function automatic int widx(input logic [31:0] a);
    return int'((a / 32'd4) % 32'd1024);
  endfunction

  task automatic mdl_write(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] m);
    for (int b = 0; b < 4; b++) begin
      if (m[b]) mdl[widx(a)][8*b +: 8] = wd[8*b +: 8];
    end
  endtask

  function automatic logic [31:0] mdl_read(input logic [31:0] a, input logic [3:0] m);
    logic [31:0] r;
    r = 32'h0;
    for (int b = 0; b < 4; b++) begin
      if (m[b]) r[8*b +: 8] = mdl[widx(a)][8*b +: 8];
    end
    return r;
  endfunction

  // One full transaction with res_ready held high; returns both responses and timing
  task automatic xact(input logic [31:0] a, input logic r, input logic w,
                      input logic [31:0] wd, input logic [3:0] m,
                      output logic [31:0] o_rd0, output logic o_e0, output int o_lat0,
                      output logic [31:0] o_rd1, output int o_lat1, output int o_rlow);
    int n;
    bit got0, got1, done;
    got0 = 1'b0; got1 = 1'b0; done = 1'b0;
    o_rd0 = 32'h0; o_e0 = 1'b0; o_lat0 = -1; o_rd1 = 32'h0; o_lat1 = -1; o_rlow = 0;
    @(negedge clk);
    req_addr = a; req_ren = r; req_wen = w; req_wdata = wd; req_mask = m; res_ready = 1'b1;
    n = 0;
    while (!rdy0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    @(negedge clk);
    req_ren = 1'b0; req_wen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (k > 0) @(negedge clk);
      if (!rdy0) o_rlow++;
      if (vld1 && !got1) begin got1 = 1'b1; o_lat1 = k; o_rd1 = rd1; end
      if (vld0 && !got0) begin got0 = 1'b1; o_lat0 = k; o_rd0 = rd0; o_e0 = err0; end
      if (got0 && got1 && rdy0) begin done = 1'b1; break; end
    end
    checks++;
    if (!done) $display("FAIL xact_timeout addr=%h got0=%0b got1=%0b", a, got0, got1);
    else passes++;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (rdy0 !== 1'b1) $display("FAIL rst_ready got=%b exp=1", rdy0); else passes++;
    checks++; if (vld0 !== 1'b0) $display("FAIL rst_valid got=%b exp=0", vld0); else passes++;
    checks++; if (rd0 !== 32'h0) $display("FAIL rst_rdata got=%h exp=0", rd0); else passes++;
    checks++; if (err0 !== 1'b0) $display("FAIL rst_err got=%b exp=0", err0); else passes++;
    rst = 1'b0;
  endtask

  task automatic test_basic;
    logic [31:0] a0, a1; logic e; int l0, l1, rl;
    xact(32'h100, 1'b0, 1'b1, 32'hDEADBEEF, 4'hF, a0, e, l0, a1, l1, rl);
    mdl_write(32'h100, 32'hDEADBEEF, 4'hF);
    checks++; if (l0 !== 2) $display("FAIL sw_latency got=%0d exp=2", l0); else passes++;
    checks++; if (a0 !== 32'h0) $display("FAIL sw_rdata got=%h exp=0", a0); else passes++;
    xact(32'h100, 1'b1, 1'b0, 32'h0, 4'hF, a0, e, l0, a1, l1, rl);
    checks++; if (a0 !== 32'hDEADBEEF) $display("FAIL lw_rdata got=%h exp=deadbeef", a0); else passes++;
    checks++; if (e !== 1'b0) $display("FAIL lw_err got=%b exp=0", e); else passes++;
    checks++; if (l0 !== 2) $display("FAIL lw_latency got=%0d exp=2", l0); else passes++;
    checks++; if (rl !== 3) $display("FAIL lw_ready_low got=%0d exp=3", rl); else passes++;
  endtask

  task automatic test_lanes;
    logic [31:0] a0, a1; logic e; int l0, l1, rl;
    xact(32'h2000, 1'b0, 1'b1, 32'h11223344, 4'hF, a0, e, l0, a1, l1, rl);
    xact(32'h2000, 1'b0, 1'b1, 32'hAA000000, 4'b1000, a0, e, l0, a1, l1, rl);
    xact(32'h2000, 1'b1, 1'b0, 32'h0, 4'hF, a0, e, l0, a1, l1, rl);
    checks++; if (a0 !== 32'hAA223344) $display("FAIL lanes_lw got=%h exp=aa223344", a0); else passes++;
    xact(32'h2000, 1'b1, 1'b0, 32'h0, 4'b1100, a0, e, l0, a1, l1, rl);
    checks++; if (a0 !== 32'hAA220000) $display("FAIL lanes_lh got=%h exp=aa220000", a0); else passes++;
    checks++; if (a1 !== 32'hAA220000) $display("FAIL lanes_lh_lat1 got=%h exp=aa220000", a1); else passes++;
  endtask

  task automatic test_backpressure;
    logic [31:0] a0, a1; logic e; int l0, l1, rl, n;
    xact(32'h300, 1'b0, 1'b1, 32'h0F0F0F0F, 4'hF, a0, e, l0, a1, l1, rl);
    @(negedge clk);
    res_ready = 1'b0;
    req_addr = 32'h100; req_ren = 1'b1; req_wen = 1'b0; req_mask = 4'hF;
    n = 0;
    while (!rdy0 && n < 20) begin @(negedge clk); n++; end
    @(posedge clk);
    @(negedge clk);
    req_addr = 32'h300; req_ren = 1'b0; req_wen = 1'b1; req_wdata = 32'hBAD0BAD0;
    n = 0;
    while (!vld0 && n < 20) begin @(negedge clk); n++; end
    for (int k = 0; k < 5; k++) begin
      checks++; if (vld0 !== 1'b1) $display("FAIL bp_valid cyc=%0d got=%b exp=1", k, vld0); else passes++;
      checks++; if (rd0 !== 32'hDEADBEEF) $display("FAIL bp_rdata cyc=%0d got=%h exp=deadbeef", k, rd0); else passes++;
      checks++; if (rdy0 !== 1'b0) $display("FAIL bp_ready cyc=%0d got=%b exp=0", k, rdy0); else passes++;
      @(negedge clk);
    end
    req_wen = 1'b0; res_ready = 1'b1;
    @(negedge clk);
    checks++; if (vld0 !== 1'b0) $display("FAIL bp_release_valid got=%b exp=0", vld0); else passes++;
    checks++; if (rdy0 !== 1'b1) $display("FAIL bp_release_ready got=%b exp=1", rdy0); else passes++;
    xact(32'h300, 1'b1, 1'b0, 32'h0, 4'hF, a0, e, l0, a1, l1, rl);
    checks++; if (a0 !== 32'h0F0F0F0F) $display("FAIL bp_no_accept got=%h exp=0f0f0f0f", a0); else passes++;
  endtask

  task automatic test_wrap;
    logic [31:0] a0, a1; logic e; int l0, l1, rl;
    xact(32'h1000, 1'b0, 1'b1, 32'h5, 4'hF, a0, e, l0, a1, l1, rl);
    mdl_write(32'h1000, 32'h5, 4'hF);
    xact(32'h0, 1'b1, 1'b0, 32'h0, 4'hF, a0, e, l0, a1, l1, rl);
    checks++; if (a0 !== 32'h5) $display("FAIL wrap_rdata got=%h exp=5", a0); else passes++;
    checks++; if (a1 !== 32'h5) $display("FAIL wrap_rdata_lat1 got=%h exp=5", a1); else passes++;
    checks++; if (l1 !== 1) $display("FAIL lat1_latency got=%0d exp=1", l1); else passes++;
  endtask

  task automatic test_reset_mid;
    logic [31:0] a0, a1; logic e; int l0, l1, rl, n; bit seen;
    xact(32'h500, 1'b0, 1'b1, 32'h77, 4'hF, a0, e, l0, a1, l1, rl);
    @(negedge clk);
    req_addr = 32'h500; req_ren = 1'b1; req_mask = 4'hF;
    n = 0;
    while (!rdy0 && n < 20) begin @(negedge clk); n++; end
    @(posedge clk);
    @(negedge clk);
    req_ren = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (rdy0 !== 1'b1) $display("FAIL rstmid_ready got=%b exp=1", rdy0); else passes++;
    seen = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (vld0 || vld1) seen = 1'b1;
      @(negedge clk);
    end
    checks++; if (seen !== 1'b0) $display("FAIL rstmid_no_resp got=%b exp=0", seen); else passes++;
    xact(32'h500, 1'b1, 1'b0, 32'h0, 4'hF, a0, e, l0, a1, l1, rl);
    checks++; if (a0 !== 32'h77) $display("FAIL rstmid_write_kept got=%h exp=77", a0); else passes++;
  endtask

  task automatic test_proto;
    logic [31:0] a0, a1; logic e; int l0, l1, rl;
    xact(32'h40, 1'b0, 1'b1, 32'h12345678, 4'hF, a0, e, l0, a1, l1, rl);
    mdl_write(32'h40, 32'h12345678, 4'hF);
    xact(32'h40, 1'b1, 1'b1, 32'hCAFEF00D, 4'hF, a0, e, l0, a1, l1, rl);
    if (!CHK) mdl_write(32'h40, 32'hCAFEF00D, 4'hF);
    checks++; if (e !== CHK) $display("FAIL proto_renwen_err got=%b exp=%b", e, CHK); else passes++;
    checks++; if (a0 !== 32'h0) $display("FAIL proto_renwen_rdata got=%h exp=0", a0); else passes++;
    xact(32'h41, 1'b0, 1'b1, 32'h000000EE, 4'hF, a0, e, l0, a1, l1, rl);
    if (!CHK) mdl_write(32'h40, 32'h000000EE, 4'hF);
    checks++; if (e !== CHK) $display("FAIL proto_misalign_err got=%b exp=%b", e, CHK); else passes++;
    xact(32'h40, 1'b0, 1'b1, 32'hFFFFFFFF, 4'b0101, a0, e, l0, a1, l1, rl);
    if (!CHK) mdl_write(32'h40, 32'hFFFFFFFF, 4'b0101);
    checks++; if (e !== CHK) $display("FAIL proto_mask_err got=%b exp=%b", e, CHK); else passes++;
    xact(32'h40, 1'b1, 1'b0, 32'h0, 4'b0000, a0, e, l0, a1, l1, rl);
    checks++; if (a0 !== 32'h0) $display("FAIL mask0_rdata got=%h exp=0", a0); else passes++;
    checks++; if (e !== CHK) $display("FAIL mask0_err got=%b exp=%b", e, CHK); else passes++;
    xact(32'h40, 1'b1, 1'b0, 32'h0, 4'hF, a0, e, l0, a1, l1, rl);
    checks++; if (a0 !== mdl_read(32'h40, 4'hF)) $display("FAIL proto_final got=%h exp=%h", a0, mdl_read(32'h40, 4'hF)); else passes++;
  endtask

  task automatic test_random;
    logic [31:0] a0, a1, a, wd, exp; logic e; int l0, l1, rl;
    logic [3:0] masks [7];
    logic [3:0] m;
    bit is_wr;
    masks = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111};
    for (int i = 0; i < 16; i++) begin
      wd = $urandom;
      a = 32'h800 + 32'(i * 4);
      xact(a, 1'b0, 1'b1, wd, 4'hF, a0, e, l0, a1, l1, rl);
      mdl_write(a, wd, 4'hF);
    end
    for (int i = 0; i < 40; i++) begin
      a = 32'h800 + 32'($urandom_range(0, 15) * 4) + 32'($urandom_range(0, 3) * 32'h1000);
      m = masks[$urandom_range(0, 6)];
      wd = $urandom;
      is_wr = ($urandom_range(0, 1) == 1);
      xact(a, !is_wr, is_wr, wd, m, a0, e, l0, a1, l1, rl);
      if (is_wr) begin
        mdl_write(a, wd, m);
        exp = 32'h0;
      end else begin
        exp = mdl_read(a, m);
      end
      checks++; if (a0 !== exp) $display("FAIL rnd_rdata i=%0d addr=%h mask=%b got=%h exp=%h", i, a, m, a0, exp); else passes++;
      checks++; if (a1 !== exp) $display("FAIL rnd_rdata_lat1 i=%0d got=%h exp=%h", i, a1, exp); else passes++;
      checks++; if (e !== 1'b0) $display("FAIL rnd_err i=%0d got=%b exp=0", i, e); else passes++;
      checks++; if (l0 !== 2) $display("FAIL rnd_latency i=%0d got=%0d exp=2", i, l0); else passes++;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_lanes();
    test_backpressure();
    test_wrap();
    test_reset_mid();
    test_proto();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
